// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx -- UART transmitter.
// Sends one byte per request as an asynchronous frame on o_txd: a start bit
// (0), eight data bits LSB first, an optional parity bit, and then one or two
// stop bits (1). Each bit lasts OVERSAMPLE ticks of the i_clk_tx enable.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   i_clk_tx    oversampling tick enable (baud x OVERSAMPLE), 1 clk wide
//   i_tx_start  transmit request, accepted only while idle
//   i_tx_data   byte to send, latched when the request is accepted
//   o_txd       serial line, idle high (registered)
//   o_tx_busy   high from acceptance until the end of the frame (registered)
//   o_tx_done   one-clk pulse at the end of the frame (registered)
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clk_tx,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_txd,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic       PAR_ODD   = 1'(PARITY_ODD);

    state_t     r_state,    w_state;
    logic [3:0] r_tick_cnt, w_tick_cnt;
    logic [7:0] r_shift,    w_shift;
    logic [2:0] r_bit_idx,  w_bit_idx;
    logic       r_parity,   w_parity;
    logic       r_stop_cnt, w_stop_cnt;
    logic       r_txd,      w_txd;
    logic       r_busy,     w_busy;
    logic       r_done,     w_done;
    logic       w_bit_end;

    // The last tick of a bit period closes the bit.
    assign w_bit_end = i_clk_tx && (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_parity   <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_tick_cnt <= w_tick_cnt;
            r_shift    <= w_shift;
            r_bit_idx  <= w_bit_idx;
            r_parity   <= w_parity;
            r_stop_cnt <= w_stop_cnt;
            r_txd      <= w_txd;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_tick_cnt = r_tick_cnt;
        w_shift    = r_shift;
        w_bit_idx  = r_bit_idx;
        w_parity   = r_parity;
        w_stop_cnt = r_stop_cnt;
        w_txd      = r_txd;
        w_busy     = r_busy;
        w_done     = 1'b0;

        // Tick counting runs only inside a frame; a tick on the acceptance
        // edge is dropped because IDLE clears the counter instead.
        if (r_state != S_IDLE && i_clk_tx) begin
            w_tick_cnt = w_bit_end ? '0 : r_tick_cnt + 4'd1;
        end

        case (r_state)
            S_IDLE: begin
                w_txd  = 1'b1;
                w_busy = 1'b0;
                if (i_tx_start) begin
                    w_shift    = i_tx_data;
                    w_parity   = (^i_tx_data) ^ PAR_ODD;
                    w_tick_cnt = '0;
                    w_bit_idx  = '0;
                    w_state    = S_START;
                    w_txd      = 1'b0;
                    w_busy     = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state = S_DATA;
                    w_txd   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift   = r_shift >> 1;
                    w_bit_idx = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            w_state = S_PARITY;
                            w_txd   = r_parity;
                        end else begin
                            w_state    = S_STOP;
                            w_txd      = 1'b1;
                            w_stop_cnt = 1'b0;
                        end
                    end else begin
                        // Line shows the bit that the shift is about to expose.
                        w_txd = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state    = S_STOP;
                    w_txd      = 1'b1;
                    w_stop_cnt = 1'b0;
                end
            end
            S_STOP: begin
                w_txd = 1'b1;
                if (w_bit_end) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_stop_cnt = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_txd   = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign o_txd     = r_txd;
    assign o_tx_busy = r_busy;
    assign o_tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
// Five transmitter instances cover default framing, even/odd parity, two stop
// bits and the minimum oversample ratio. Expected line bits are queued when a
// frame is launched and popped at the middle of each received bit period.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [4:0] start;
    logic [7:0] data_s [5];
    logic [4:0] txd, busy, done;

    int os_of    [5] = '{16, 16, 16, 16, 2};
    bit par_of   [5] = '{0, 1, 1, 0, 0};
    int stops_of [5] = '{1, 1, 1, 2, 1};

    int   tick_div = 1;
    int   tick_ph  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   overlap_errs = 0;
    int   bad;
    logic exp_q [$];

    typedef struct {
        int         d;
        logic [7:0] data;
        int         div;
        logic       par;
        int         nbits;
    } vec_t;
    vec_t vecs [9];

    always #5 clk = ~clk;

    // Tick enable with a programmable period, changed away from the active edge.
    always @(negedge clk) begin
        tick_ph = (tick_ph + 1) % tick_div;
        tick    = (tick_ph == 0);
    end

    always @(negedge clk) begin
        if ((busy & done) != 5'b0) overlap_errs++;
    end

    uart_tx u_def (
        .clk(clk), .reset(reset), .i_clk_tx(tick), .i_tx_start(start[0]),
        .i_tx_data(data_s[0]), .o_txd(txd[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0])
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_par_even (
        .clk(clk), .reset(reset), .i_clk_tx(tick), .i_tx_start(start[1]),
        .i_tx_data(data_s[1]), .o_txd(txd[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1])
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_par_odd (
        .clk(clk), .reset(reset), .i_clk_tx(tick), .i_tx_start(start[2]),
        .i_tx_data(data_s[2]), .o_txd(txd[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2])
    );
    uart_tx #(.STOP_BITS(2)) u_stop2 (
        .clk(clk), .reset(reset), .i_clk_tx(tick), .i_tx_start(start[3]),
        .i_tx_data(data_s[3]), .o_txd(txd[3]), .o_tx_busy(busy[3]), .o_tx_done(done[3])
    );
    uart_tx #(.OVERSAMPLE(2)) u_os2 (
        .clk(clk), .reset(reset), .i_clk_tx(tick), .i_tx_start(start[4]),
        .i_tx_data(data_s[4]), .o_txd(txd[4]), .o_tx_busy(busy[4]), .o_tx_done(done[4])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected line sequence of one frame: start, data LSB first, parity, stops.
    function automatic void push_frame(input int d, input logic [7:0] v, input logic par);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(v[i]);
        if (par_of[d]) exp_q.push_back(par);
        for (int i = 0; i < stops_of[d]; i++) exp_q.push_back(1'b1);
    endfunction

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic launch(input int d, input logic [7:0] v, input logic par);
        data_s[d] = v;
        start[d]  = 1'b1;
        push_frame(d, v, par);
        @(posedge clk);
        @(negedge clk);
        start[d]  = 1'b0;
        data_s[d] = ~v;
        chk($sformatf("d%0d_accept_busy", d), busy[d], 1);
        chk($sformatf("d%0d_accept_txd", d), txd[d], 0);
    endtask

    // Follows a frame already accepted: samples each bit mid-period against the
    // queue, then checks frame length in ticks, the done pulse and the idle line.
    task automatic frame_check(input int d, input int nbits, input bit next_busy);
        int os    = os_of[d];
        int ticks = 0;
        int clks  = 0;
        int limit = nbits * os * tick_div + 8;
        bit was_tick = 0;
        bit ended    = 0;
        logic eb;
        while (!ended && clks < limit) begin
            @(posedge clk);
            was_tick = tick;
            @(negedge clk);
            clks++;
            if (was_tick) ticks++;
            if (!busy[d]) begin
                ended = 1;
            end else if (was_tick && (ticks % os) == os / 2) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("d%0d_extra_bit", d), ticks, nbits * os);
                end else begin
                    eb = exp_q.pop_front();
                    chk($sformatf("d%0d_bit%0d", d, ticks / os), txd[d], eb);
                end
            end
        end
        chk($sformatf("d%0d_frame_end_seen", d), ended, 1);
        chk($sformatf("d%0d_frame_ticks", d), ticks, nbits * os);
        chk($sformatf("d%0d_end_on_tick", d), was_tick, 1);
        chk($sformatf("d%0d_done_pulse", d), done[d], 1);
        chk($sformatf("d%0d_line_idle_at_done", d), txd[d], 1);
        if (tick_div == 1) chk($sformatf("d%0d_busy_clks", d), clks, nbits * os);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("d%0d_done_one_clk", d), done[d], 0);
        chk($sformatf("d%0d_busy_after", d), busy[d], next_busy);
        chk($sformatf("d%0d_txd_after", d), txd[d], !next_busy);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'hA5, 1, 1'b0, 10};
        vecs[1] = '{0, 8'h3C, 3, 1'b0, 10};
        vecs[2] = '{1, 8'h07, 1, 1'b1, 11};
        vecs[3] = '{2, 8'h07, 1, 1'b0, 11};
        vecs[4] = '{1, 8'hC3, 2, 1'b0, 11};
        vecs[5] = '{2, 8'hC3, 1, 1'b1, 11};
        vecs[6] = '{3, 8'h3C, 1, 1'b0, 11};
        vecs[7] = '{4, 8'h6E, 1, 1'b0, 10};
        vecs[8] = '{4, 8'h01, 5, 1'b0, 10};

        reset = 1'b0;
        tick  = 1'b0;
        start = '0;
        for (int i = 0; i < 5; i++) data_s[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_txd", txd, 5'b11111);
        chk("reset_busy", busy, 5'b00000);
        chk("reset_done", done, 5'b00000);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven frames.
        for (int k = 0; k < 9; k++) begin
            tick_div = vecs[k].div;
            @(negedge clk);
            launch(vecs[k].d, vecs[k].data, vecs[k].par);
            frame_check(vecs[k].d, vecs[k].nbits, 1'b0);
        end

        // Back-to-back with request held high and sparse ticks.
        tick_div = 4;
        @(negedge clk);
        data_s[0] = 8'h00;
        start[0]  = 1'b1;
        push_frame(0, 8'h00, 1'b0);
        push_frame(0, 8'hFF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_accept_busy", busy[0], 1);
        chk("b2b_accept_txd", txd[0], 0);
        data_s[0] = 8'hFF;
        frame_check(0, 10, 1'b1);
        start[0] = 1'b0;
        frame_check(0, 10, 1'b0);

        // Two stop bits; a request in mid-frame must be dropped.
        tick_div = 1;
        @(negedge clk);
        launch(3, 8'h3C, 1'b0);
        fork
            frame_check(3, 11, 1'b0);
            begin
                repeat (50) @(negedge clk);
                data_s[3] = 8'h81;
                start[3]  = 1'b1;
                @(negedge clk);
                start[3]  = 1'b0;
            end
        join
        bad = 0;
        repeat (48) begin
            @(negedge clk);
            if (txd[3] !== 1'b1 || busy[3] !== 1'b0) bad++;
        end
        chk("ignored_start_no_frame", bad, 0);

        // Reset in the middle of an all-ones frame.
        launch(0, 8'hFF, 1'b0);
        repeat (40) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midframe_reset_txd", txd[0], 1);
        chk("midframe_reset_busy", busy[0], 0);
        chk("midframe_reset_done", done[0], 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
        end
        chk("idle_after_reset", bad, 0);

        // Reset at data bit 3 of 0x55, then a clean 0x0F frame.
        launch(0, 8'h55, 1'b0);
        repeat (72) @(negedge clk);
        chk("bit3_of_55", txd[0], 0);
        #1 reset = 1'b0;
        #1;
        chk("bit3_reset_txd", txd[0], 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        launch(0, 8'h0F, 1'b0);
        frame_check(0, 10, 1'b0);

        chk("queue_drained", exp_q.size(), 0);
        chk("no_busy_done_overlap", overlap_errs, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter. Serialises one byte per request into an asynchronous frame on o_txd: start bit (0), 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits (1). Bit timing comes from an external oversampling tick enable (i_clk_tx, baud x OVERSAMPLE) produced by the shared baud divider, the same tick scheme the receive path uses. The block pairs with the UART receiver to form the full-duplex UART.

Parameters:
OVERSAMPLE, 16, number of i_clk_tx ticks per bit period (range 2..16, 4-bit counter)
PARITY_EN, 0, 1 = insert parity bit after D7
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
i_clk_tx  input  1  oversampling tick enable, one clk cycle wide, baud x OVERSAMPLE
i_tx_start  input  1  transmit request, sampled on clk edge
i_tx_data  input  8  byte to send, sampled when request accepted
o_txd  output  1  serial line, idle high, registered
o_tx_busy  output  1  high from acceptance until frame end, registered
o_tx_done  output  1  one-clk pulse at frame end, registered

Behaviour:
- Reset (async, reset=0): state IDLE, o_txd=1, o_tx_busy=0, o_tx_done=0, tick counter=0, shift register=0, bit index=0. Reset mid-frame aborts immediately; line returns high with no partial stop bit.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_txd=1. Edge with i_tx_start=1 = acceptance: latch i_tx_data into shift register, compute parity (even = XOR of 8 bits; odd = inverted), clear tick counter and bit index, go START. o_txd=0 and o_tx_busy=1 on that same edge.
- i_tx_start while o_tx_busy=1 is ignored (not queued); i_tx_data changes after acceptance have no effect.
- Bit period: tick counter increments on every clk with i_clk_tx=1. The edge with i_clk_tx=1 and counter==OVERSAMPLE-1 ends the bit: counter wraps to 0, FSM advances, o_txd takes the next bit value on that edge. Each bit is therefore exactly OVERSAMPLE ticks long. clk edges without a tick hold all state.
- START -> DATA. DATA: o_txd = shift register bit 0; at each bit end shift right and increment bit index. After the 8th data bit: PARITY if PARITY_EN, else STOP.
- PARITY: o_txd = parity bit for one bit period -> STOP.
- STOP: o_txd=1 for STOP_BITS bit periods. At the end of the last stop bit: state IDLE, o_tx_busy=0, o_tx_done=1 for exactly one clk, o_txd stays 1.
- Back-to-back: i_tx_start sampled in IDLE on the edge after done. Minimum frame-to-frame gap is 1 clk beyond the stop bits.
- Frame length in ticks: (1 + 8 + PARITY_EN + STOP_BITS) x OVERSAMPLE.
- An i_clk_tx tick coinciding with the acceptance edge does not count toward the start bit.
- o_tx_done never overlaps o_tx_busy.

Test Plan:
- Reset: hold reset=0 mid-frame with data 0xFF -> o_txd=1, busy=0, done=0 asynchronously. Release reset -> line stays idle high until the next i_tx_start.
- Default params, i_clk_tx tied 1, send 0xA5 -> o_txd for 16 clk each: 0,1,0,1,0,0,1,0,1,1. busy high for 160 clk. done pulses 1 clk after the last stop clk.
- i_clk_tx every 4th clk, send 0x00 then 0xFF back-to-back (start held high) -> each bit lasts 64 clk. Second frame starts 1 clk after the first done. Line pattern is correct for both bytes.
- PARITY_EN=1: 0x07 with PARITY_ODD=0 -> parity bit 1; same byte with PARITY_ODD=1 -> parity bit 0. Frame is 11 bit periods.
- STOP_BITS=2, send 0x3C -> stop high for 32 ticks before done. Pulse i_tx_start with 0x81 mid-frame -> ignored; no second frame follows.
- Assert reset mid-DATA at bit 3 of 0x55, then send 0x0F -> clean new frame: start bit, then 1,1,1,1,0,0,0,0, then stop. No residue from 0x55.
